// File: rtl/demux5_5.sv
// demux5_5: five-way registered distributor.
// One producer word (data_in + selector) is parked in one of five holding
// slots, each with its own valid/ack handshake toward an independent consumer.
// A word is accepted only when its target slot is empty or drained this cycle.
module demux5_5 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       selector,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic [WIDTH-1:0] data_out_2,
  output logic [WIDTH-1:0] data_out_3,
  output logic [WIDTH-1:0] data_out_4,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ack,
  output logic             sel_err,
  output logic [CNT_W-1:0] xfer_count
);

  logic [2:0]       slot;      // effective slot after out-of-range folding
  logic             accept;    // word transferred at the coming edge
  logic             sel_oob;   // selector outside 000..100
  logic [4:0]       wr;        // one-hot write strobe per slot
  logic [WIDTH-1:0] data_q [5];

  // Slot decode, back-pressure and per-slot write strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    slot     = 3'd0;
    sel_oob  = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    wr       = '0;

    sel_oob = (selector > 3'd4);
    // Out-of-range selectors fall back to slot 0, matching the read-side mux.
    slot    = sel_oob ? 3'd0 : selector;

    // A slot is writable when empty, or when its consumer drains it this cycle.
    in_ready = !reset && (!out_valid[slot] || out_ack[slot]);
    accept   = in_valid && in_ready;
    if (accept) begin
      wr = 5'b00001 << slot;
    end
  end

  // Slot data registers: loaded on write, otherwise held (ack does not clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the holding slots are cleared on reset because consumers see
      // zero data after a flush; these are five registers, not a RAM macro.
      for (int i = 0; i < 5; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wr[i]) begin
          // NOTE: non-blocking assignment so every register samples pre-edge
          // values regardless of statement order.
          data_q[i] <= data_in;
        end
      end
    end
  end

  // Valid flags, transfer counter and the one-cycle out-of-range pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= '0;
      xfer_count <= '0;
      sel_err    <= 1'b0;
    end else begin
      // Ack on an empty slot is a no-op; a same-cycle write keeps the slot full.
      out_valid  <= (out_valid & ~out_ack) | wr;
      xfer_count <= xfer_count + {{(CNT_W-1){1'b0}}, accept};
      sel_err    <= accept && sel_oob;
    end
  end

  assign data_out_0 = data_q[0];
  assign data_out_1 = data_q[1];
  assign data_out_2 = data_q[2];
  assign data_out_3 = data_q[3];
  assign data_out_4 = data_q[4];

endmodule

// File: tb/tb_demux5_5.sv
// tb_demux5_5: directed scoreboard bench for demux5_5.
// A 16-bit-counter instance and a 4-bit-counter instance share one stimulus.
module tb_demux5_5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  selector;
  logic [31:0] data_in;
  logic        in_valid;
  logic [4:0]  out_ack;

  logic        in_ready;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
  logic [4:0]  out_valid;
  logic        sel_err;
  logic [15:0] xfer_count;

  logic        in_ready_n;
  logic [31:0] data_out_0_n, data_out_1_n, data_out_2_n, data_out_3_n, data_out_4_n;
  logic [4:0]  out_valid_n;
  logic        sel_err_n;
  logic [3:0]  xfer_count_n;

  demux5_5 #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4),
    .out_valid(out_valid), .out_ack(out_ack), .sel_err(sel_err),
    .xfer_count(xfer_count)
  );

  demux5_5 #(.WIDTH(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .data_out_0(data_out_0_n), .data_out_1(data_out_1_n), .data_out_2(data_out_2_n),
    .data_out_3(data_out_3_n), .data_out_4(data_out_4_n),
    .out_valid(out_valid_n), .out_ack(out_ack), .sel_err(sel_err_n),
    .xfer_count(xfer_count_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model of the slot state.
  logic [4:0]  m_valid;
  logic [31:0] m_data [5];
  int          m_count;
  logic        m_sel_err;

  function automatic logic [31:0] dout(input int i);
    case (i)
      0:       return data_out_0;
      1:       return data_out_1;
      2:       return data_out_2;
      3:       return data_out_3;
      default: return data_out_4;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid   = '0;
    for (int i = 0; i < 5; i++) m_data[i] = '0;
    m_count   = 0;
    m_sel_err = 1'b0;
    sb.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".sel_err"}, 32'(sel_err), 32'(m_sel_err));
    check({tag, ".xfer_count"}, 32'(xfer_count), 32'(m_count % 65536));
    check({tag, ".xfer_count4"}, 32'(xfer_count_n), 32'(m_count % 16));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s.data_out_%0d", tag, i), dout(i), m_data[i]);
    end
  endtask

  // Drive one cycle of stimulus (entered at posedge+1), check in_ready,
  // push the expected word, clock, then pop and compare.
  task automatic cycle(input string tag, input logic v, input logic [2:0] s,
                       input logic [31:0] d, input logic [4:0] a);
    int   slot;
    logic rdy;
    logic acc;
    exp_t e;
    in_valid = v;
    selector = s;
    data_in  = d;
    out_ack  = a;
    #1;
    slot = (s > 3'd4) ? 0 : int'(s);
    rdy  = !m_valid[slot] || a[slot];
    acc  = v && rdy;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    if (acc) begin
      e.slot = slot;
      e.data = d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (acc && slot == i) begin
        m_valid[i] = 1'b1;
        m_data[i]  = d;
      end else if (a[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (acc) m_count++;
    m_sel_err = acc && (s > 3'd4);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".sb_data"}, dout(e.slot), e.data);
      check({tag, ".sb_valid"}, 32'(out_valid[e.slot]), 32'd1);
    end
    check_all(tag);
  endtask

  initial begin
    reset    = 1'b1;
    selector = 3'd4;
    data_in  = 32'hDEAD_0000;
    in_valid = 1'b1;
    out_ack  = 5'b0;
    model_reset();
    #12;
    // Reset state, with a producer word waiting.
    check("reset.in_ready", 32'(in_ready), 32'd0);
    check_all("reset");
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Fill slots 0..4 with no acks.
    for (int i = 0; i < 5; i++) begin
      cycle($sformatf("fill%0d", i), 1'b1, 3'(i), 32'hA0 + 32'(i), 5'b0);
    end
    check("fill.out_valid", 32'(out_valid), 32'h1F);
    check("fill.count", 32'(xfer_count), 32'd5);

    // Back-pressure on slot 2, then drain and refill in one cycle.
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("stall%0d", k), 1'b1, 3'd2, 32'hBEEF, 5'b0);
      check("stall.data2", data_out_2, 32'hA2);
    end
    cycle("drain2", 1'b1, 3'd2, 32'hBEEF, 5'b00100);
    check("drain2.data2", data_out_2, 32'hBEEF);
    check("drain2.valid2", 32'(out_valid[2]), 32'd1);

    // Out-of-range selector lands in slot 0 and pulses sel_err once.
    cycle("oob", 1'b1, 3'b110, 32'h1234, 5'b00001);
    check("oob.data0", data_out_0, 32'h1234);
    check("oob.sel_err", 32'(sel_err), 32'd1);
    check("oob.count", 32'(xfer_count), 32'd7);
    cycle("oob_idle", 1'b0, 3'd7, 32'h0, 5'b0);
    check("oob_idle.sel_err", 32'(sel_err), 32'd0);

    // Leave only slots 1 and 3 valid, then ack everything.
    cycle("ack_even", 1'b0, 3'd0, 32'h0, 5'b10101);
    check("ack_even.out_valid", 32'(out_valid), 32'h0A);
    cycle("ack_all", 1'b0, 3'd0, 32'h0, 5'b11111);
    check("ack_all.out_valid", 32'(out_valid), 32'h00);
    check("ack_all.data3", data_out_3, 32'hA3);

    // Build 10110, then asynchronous reset between edges.
    cycle("pre1", 1'b1, 3'd1, 32'hC1, 5'b0);
    cycle("pre2", 1'b1, 3'd2, 32'hC2, 5'b0);
    cycle("pre4", 1'b1, 3'd4, 32'hC4, 5'b0);
    check("pre.out_valid", 32'(out_valid), 32'h16);
    in_valid = 1'b1;
    selector = 3'd4;
    data_in  = 32'hD4;
    out_ack  = 5'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async.in_ready", 32'(in_ready), 32'd0);
    check_all("async");
    @(posedge clk);
    #1;
    check_all("async_hold");
    reset = 1'b0;
    cycle("post4", 1'b1, 3'd4, 32'hD4, 5'b0);
    check("post4.out_valid", 32'(out_valid), 32'h10);

    // Counter wrap: 16 more accepts into slot 3 with ack every cycle.
    for (int i = 0; i < 16; i++) begin
      cycle($sformatf("wrap%0d", i), 1'b1, 3'd3, 32'hE0 + 32'(i), 5'b01000);
    end
    check("wrap.count16", 32'(xfer_count), 32'd17);
    check("wrap.count4", 32'(xfer_count_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux5_5.md
# demux5_5

Five-way registered distributor: takes one 32-bit word with a 3-bit selector and parks it in one of five output holding slots, each with its own valid/acknowledge handshake. It is the write-side counterpart of the datapath's five-input selector mux. It sits between a single producer (ALU/memory-data path) and up to five independent consumers. Back-pressure is per slot: a word is only accepted when its target slot is free or is being drained in the same cycle.

## Interface
- WIDTH, 32, data width of input and every slot
- CNT_W, 16, width of the transfer counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- selector  in  3  target slot; 000..100 select slots 0..4
- data_in  in  WIDTH  word to distribute
- in_valid  in  1  producer has a word this cycle
- in_ready  out  1  block accepts the word this cycle (combinational)
- data_out_0 .. data_out_4  out  WIDTH each  slot holding registers
- out_valid  out  5  bit i = slot i holds an unconsumed word
- out_ack  in  5  bit i = consumer i takes slot i this cycle
- sel_err  out  1  registered one-cycle pulse: an out-of-range selector was accepted
- xfer_count  out  CNT_W  number of accepted words, wraps

## Operation
- Effective slot s = selector for 000..100; selectors 101..111 map to slot 0, same default as the mux.
- in_ready = !reset && (!out_valid[s] || out_ack[s]).
- Accept = in_valid && in_ready. On accept: data_out_s <= data_in, out_valid[s] <= 1, xfer_count <= xfer_count + 1 (mod 2^CNT_W), sel_err <= (selector > 3'b100).
- No accept: sel_err <= 0. Hold all data registers.
- out_ack[i] with out_valid[i]=1: out_valid[i] <= 0, unless the same cycle accepts into slot i. In that case out_valid[i] stays 1 and data_out_i takes the new word.
- out_ack[i] with out_valid[i]=0 is ignored. No state change, no error.
- Multiple out_ack bits may be high in one cycle. Each slot is handled independently.
- data_out_i is held stable while out_valid[i]=1 and no new accept targets slot i. Data is not cleared on ack; the last value stays visible.
- in_valid low: selector and data_in are don't-care.

## Timing
- Reset (asynchronous): data_out_0..4 = 0, out_valid = 5'b00000, sel_err = 0, xfer_count = 0.
- in_ready is held 0 while reset is high. After release it reflects state in the same cycle.
- Latency: a word accepted at edge N is visible on data_out_s, with out_valid[s]=1, right after edge N.
- Throughput: one word per cycle. This holds when words go to distinct free slots, or to one slot whose consumer acks every cycle.
- A full slot with no ack holds in_ready low for that selector. Producer must keep in_valid, selector and data_in stable until acceptance. Stalling on one slot never blocks the others except through the single input port.
- xfer_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-transfer drops every held word. Consumers must treat out_valid falling without ack as a flush.

## Test plan
- Reset then fill: write 0xA0..0xA4 to selectors 0..4 on consecutive cycles, no acks -> out_valid goes 00001, 00011, ... 11111 one cycle after each write; xfer_count=5; data_out_i=0xA0+i.
- Back-pressure: slot 2 full, present 0xBEEF to selector 2 with out_ack=0 for 3 cycles -> in_ready=0, data_out_2 unchanged. Assert out_ack[2] -> in_ready=1 that cycle, data_out_2=0xBEEF next cycle, out_valid[2] stays 1.
- Out-of-range: accept 0x1234 with selector 110 -> data_out_0=0x1234, out_valid[0]=1, sel_err high exactly one cycle, xfer_count+1.
- Spurious and multi ack: out_ack=11111 with only slots 1 and 3 valid -> out_valid 01010 -> 00000, other slots untouched, no sel_err.
- Async reset mid-stream: assert reset between edges while out_valid=10110 -> all outputs 0 immediately, in_ready=0; after release first write to slot 4 is accepted the next edge.
- Counter wrap with CNT_W=4: 17 accepts -> xfer_count reads 1.
